// File: rtl/fifo_mc_if.sv
// Write/read/status bundle for fifo_mc. Defining FIFO_MC_ERR_STICKY_EN adds err_clr_i, ovf_o and udf_o.
interface fifo_mc_if #(
  parameter int DWIDTH   = 64,
  parameter int AWIDTH   = 4,
  parameter int CHANNELS = 4
);
  localparam int CHW = $clog2(CHANNELS);

  logic [DWIDTH-1:0]              data_i;
  logic                           wrreq_i;
  logic [CHW-1:0]                 wrch_i;
  logic                           rdreq_i;
  logic [CHW-1:0]                 rdch_i;
  logic [DWIDTH-1:0]              q_o;
  logic                           q_valid_o;
  logic [CHW-1:0]                 q_ch_o;
  logic [CHANNELS-1:0]            empty_o;
  logic [CHANNELS-1:0]            full_o;
  logic [CHANNELS-1:0]            almost_full_o;
  logic [CHANNELS-1:0]            almost_empty_o;
  logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o;

`ifdef FIFO_MC_ERR_STICKY_EN
  logic                           err_clr_i;
  logic [CHANNELS-1:0]            ovf_o;
  logic [CHANNELS-1:0]            udf_o;

  modport slave (
    input  data_i, wrreq_i, wrch_i, rdreq_i, rdch_i, err_clr_i,
    output q_o, q_valid_o, q_ch_o, empty_o, full_o, almost_full_o, almost_empty_o,
           usedw_o, ovf_o, udf_o
  );
  modport master (
    output data_i, wrreq_i, wrch_i, rdreq_i, rdch_i, err_clr_i,
    input  q_o, q_valid_o, q_ch_o, empty_o, full_o, almost_full_o, almost_empty_o,
           usedw_o, ovf_o, udf_o
  );
`else
  modport slave (
    input  data_i, wrreq_i, wrch_i, rdreq_i, rdch_i,
    output q_o, q_valid_o, q_ch_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o
  );
  modport master (
    output data_i, wrreq_i, wrch_i, rdreq_i, rdch_i,
    input  q_o, q_valid_o, q_ch_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o
  );
`endif
endinterface

// File: rtl/fifo_mc.sv
// Multi-channel FIFO bank: CHANNELS queues in one shared array, one write and one read port, registered read data.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_MC_ERR_STICKY_EN.
module fifo_mc #(
  parameter int DWIDTH             = 64,
  parameter int AWIDTH             = 4,
  parameter int CHANNELS           = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic      clk_i,
  input  logic      arst_n_i,
  fifo_mc_if.slave  bus
);
  localparam int              CHW      = $clog2(CHANNELS);
  localparam int              DEPTH    = 2 ** AWIDTH;
  localparam int              ADW      = CHW + AWIDTH;
  localparam logic [CHW:0]    CH_LIM   = (CHW+1)'(CHANNELS);
  localparam logic [AWIDTH:0] FULL_LVL = {1'b1, {AWIDTH{1'b0}}};
  localparam logic            AE_RST   = (ALMOST_EMPTY_VALUE > 0);

  logic [DWIDTH-1:0] mem_q [CHANNELS*DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q [CHANNELS];
  logic [AWIDTH-1:0] wr_ptr_d [CHANNELS];
  logic [AWIDTH-1:0] rd_ptr_q [CHANNELS];
  logic [AWIDTH-1:0] rd_ptr_d [CHANNELS];
  logic [AWIDTH:0]   usedw_q  [CHANNELS];
  logic [AWIDTH:0]   usedw_d  [CHANNELS];

  logic [CHANNELS-1:0] empty_q, empty_d, full_q, full_d;
  logic [CHANNELS-1:0] af_q, af_d, ae_q, ae_d;
  logic [CHANNELS-1:0] wr_hit, rd_hit;

  logic           wr_ok, rd_ok, wr_acc, rd_acc;
  logic [ADW-1:0] wr_addr, rd_addr;

  logic              vld_p0_q;
  logic [ADW-1:0]    addr_p0_q;
  logic [CHW-1:0]    ch_p0_q;
  logic              vld_p1_q;
  logic [DWIDTH-1:0] q_p1_q;
  logic [CHW-1:0]    ch_p1_q;

  // Acceptance uses this cycle's registered flags, so a full channel drops a
  // simultaneous write and an empty channel drops a simultaneous read.
  always_comb begin
    wr_ok   = ({1'b0, bus.wrch_i} < CH_LIM);
    rd_ok   = ({1'b0, bus.rdch_i} < CH_LIM);
    wr_acc  = bus.wrreq_i && wr_ok && !full_q[bus.wrch_i];
    rd_acc  = bus.rdreq_i && rd_ok && !empty_q[bus.rdch_i];
    wr_addr = {bus.wrch_i, wr_ptr_q[bus.wrch_i]};
    rd_addr = {bus.rdch_i, rd_ptr_q[bus.rdch_i]};
    wr_hit  = '0;
    rd_hit  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c]   = wr_acc && (bus.wrch_i == CHW'(c));
      rd_hit[c]   = rd_acc && (bus.rdch_i == CHW'(c));
      wr_ptr_d[c] = wr_ptr_q[c] + AWIDTH'(wr_hit[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AWIDTH'(rd_hit[c]);
      usedw_d[c]  = usedw_q[c];
      if (wr_hit[c] && !rd_hit[c])      usedw_d[c] = usedw_q[c] + 1'b1;
      else if (rd_hit[c] && !wr_hit[c]) usedw_d[c] = usedw_q[c] - 1'b1;
      empty_d[c] = (usedw_d[c] == '0);
      full_d[c]  = (usedw_d[c] == FULL_LVL);
      af_d[c]    = (int'(usedw_d[c]) >= ALMOST_FULL_VALUE);
      ae_d[c]    = (int'(usedw_d[c]) <  ALMOST_EMPTY_VALUE);
    end
  end

  // Stage p0: storage write and read-address capture (data path, no reset)
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_addr] <= bus.data_i;
    if (rd_acc) begin
      addr_p0_q <= rd_addr;
      ch_p0_q   <= bus.rdch_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        usedw_q[c]  <= '0;
      end
      empty_q  <= '1;
      full_q   <= '0;
      af_q     <= '0;
      ae_q     <= {CHANNELS{AE_RST}};
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      q_p1_q   <= '0;
      ch_p1_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      vld_p0_q <= rd_acc;
      // Stage p1: array read of the p0 address into the output register
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) begin
        q_p1_q  <= mem_q[addr_p0_q];
        ch_p1_q <= ch_p0_q;
      end
    end
  end

  assign bus.q_o            = q_p1_q;
  assign bus.q_valid_o      = vld_p1_q;
  assign bus.q_ch_o         = ch_p1_q;
  assign bus.empty_o        = empty_q;
  assign bus.full_o         = full_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_usedw
    assign bus.usedw_o[g*(AWIDTH+1) +: AWIDTH+1] = usedw_q[g];
  end

`ifdef FIFO_MC_ERR_STICKY_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d, udf_q, udf_d;

  // A set event in the same cycle as err_clr_i wins over the clear.
  always_comb begin
    ovf_d = '0;
    udf_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ovf_d[c] = (ovf_q[c] && !bus.err_clr_i) ||
                 (bus.wrreq_i && wr_ok && (bus.wrch_i == CHW'(c)) && full_q[c]);
      udf_d[c] = (udf_q[c] && !bus.err_clr_i) ||
                 (bus.rdreq_i && rd_ok && (bus.rdch_i == CHW'(c)) && empty_q[c]);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
  assign bus.udf_o = udf_q;
`endif
endmodule

// File: tb/tb_fifo_mc.sv
// Bench for fifo_mc: directed scenarios plus randomized traffic against a per-channel queue model.
module tb_fifo_mc;
  localparam int DW   = 64;
  localparam int AW   = 4;
  localparam int CH   = 4;
  localparam int AFV  = 12;
  localparam int AEV  = 2;
  localparam int CHW  = $clog2(CH);
  localparam int UW   = AW + 1;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_mc_if #(.DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH)) bus ();

  fifo_mc #(
    .DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH),
    .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
  ) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  string phase = "init";

  logic [DW-1:0] mq [CH][$];
  bit            pend_v, exp_v;
  logic [DW-1:0] pend_d, exp_q;
  int            pend_ch, exp_ch;
  bit [CH-1:0]   m_ovf, m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [CH-1:0]    e_emp, e_full, e_af, e_ae;
    logic [CH*UW-1:0] e_uw;
    int sz;
    for (int c = 0; c < CH; c++) begin
      sz = mq[c].size();
      e_emp[c]  = (sz == 0);
      e_full[c] = (sz == DEPTH);
      e_af[c]   = (sz >= AFV);
      e_ae[c]   = (sz < AEV);
      e_uw[c*UW +: UW] = UW'(sz);
    end
    chk("q_valid", 64'(bus.q_valid_o), 64'(exp_v));
    chk("q", 64'(bus.q_o), 64'(exp_q));
    chk("q_ch", 64'(bus.q_ch_o), 64'(exp_ch));
    chk("empty", 64'(bus.empty_o), 64'(e_emp));
    chk("full", 64'(bus.full_o), 64'(e_full));
    chk("almost_full", 64'(bus.almost_full_o), 64'(e_af));
    chk("almost_empty", 64'(bus.almost_empty_o), 64'(e_ae));
    chk("usedw", 64'(bus.usedw_o), 64'(e_uw));
`ifdef FIFO_MC_ERR_STICKY_EN
    chk("ovf", 64'(bus.ovf_o), 64'(m_ovf));
    chk("udf", 64'(bus.udf_o), 64'(m_udf));
`endif
  endtask

  task automatic drive_idle();
    bus.wrreq_i = 1'b0;
    bus.wrch_i  = '0;
    bus.data_i  = '0;
    bus.rdreq_i = 1'b0;
    bus.rdch_i  = '0;
`ifdef FIFO_MC_ERR_STICKY_EN
    bus.err_clr_i = 1'b0;
`endif
  endtask

  // One clock: drive, predict acceptance from the model, step the model at the edge, then check.
  task automatic cycle(input bit wr, input int wch, input logic [DW-1:0] wd,
                       input bit rd, input int rch, input bit clr);
    bit wacc, racc;
    bus.wrreq_i = wr;
    bus.wrch_i  = CHW'(wch);
    bus.data_i  = wd;
    bus.rdreq_i = rd;
    bus.rdch_i  = CHW'(rch);
`ifdef FIFO_MC_ERR_STICKY_EN
    bus.err_clr_i = clr;
`endif
    wacc = wr && (mq[wch].size() < DEPTH);
    racc = rd && (mq[rch].size() > 0);
    if (clr) begin
      m_ovf = '0;
      m_udf = '0;
    end
    if (wr && !wacc) m_ovf[wch] = 1'b1;
    if (rd && !racc) m_udf[rch] = 1'b1;
    @(posedge clk);
    exp_v = pend_v;
    if (pend_v) begin
      exp_q  = pend_d;
      exp_ch = pend_ch;
    end
    pend_v = racc;
    if (racc) begin
      pend_d  = mq[rch].pop_front();
      pend_ch = rch;
    end
    if (wacc) mq[wch].push_back(wd);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must take their reset values at once.
  task automatic do_reset();
    #2 arst_n = 1'b0;
    #1;
    for (int c = 0; c < CH; c++) mq[c].delete();
    pend_v = 1'b0;
    exp_v  = 1'b0;
    exp_q  = '0;
    exp_ch = 0;
    m_ovf  = '0;
    m_udf  = '0;
    drive_idle();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    pend_v = 1'b0; exp_v = 1'b0; exp_q = '0; exp_ch = 0; pend_d = '0; pend_ch = 0;
    m_ovf = '0; m_udf = '0;
    drive_idle();
    @(posedge clk);
    #1;
    phase = "reset";
    do_reset();

    phase = "ch2_seq";
    cycle(1'b1, 2, 64'h11, 1'b0, 0, 1'b0);
    cycle(1'b1, 2, 64'h22, 1'b0, 0, 1'b0);
    cycle(1'b1, 2, 64'h33, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, 1'b1, 2, 1'b0);
    idle(2);

    phase = "fill_ch0";
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 0, {$urandom, $urandom}, 1'b0, 0, 1'b0);
    idle(1);

    phase = "ch1_full_rw";
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1, {$urandom, $urandom}, 1'b0, 0, 1'b0);
    cycle(1'b1, 1, 64'hdead, 1'b1, 1, 1'b0);
    idle(2);

    phase = "ch3_empty_rw";
    cycle(1'b1, 3, 64'hbeef, 1'b1, 3, 1'b0);
    idle(2);

    phase = "sticky";
    cycle(1'b0, 0, '0, 1'b1, 2, 1'b0);
    cycle(1'b0, 0, '0, 1'b0, 0, 1'b1);
    cycle(1'b0, 0, '0, 1'b1, 2, 1'b1);
    idle(1);

    phase = "reset_mid";
    for (int i = 0; i < DEPTH / 2; i++) cycle(1'b0, 0, '0, 1'b1, 0, 1'b0);
    cycle(1'b0, 0, '0, 1'b1, 0, 1'b0);
    do_reset();
    idle(2);
    cycle(1'b1, 0, 64'h0123_4567_89ab_cdef, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, '0, 1'b1, 0, 1'b0);
    idle(2);

    phase = "interleave";
    for (int i = 0; i < 2 * (DEPTH + 5); i++) begin
      if (i % 2 == 0) cycle(1'b1, 0, {32'd0, 32'(i)}, 1'b1, 1, 1'b0);
      else            cycle(1'b1, 1, {32'd1, 32'(i)}, 1'b1, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, '0, 1'b1, i % 2, 1'b0);
    idle(2);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < ((i < 200) ? 80 : 30), int'($urandom_range(0, CH - 1)),
            {$urandom, $urandom},
            $urandom_range(0, 99) < ((i < 200) ? 30 : 80), int'($urandom_range(0, CH - 1)),
            $urandom_range(0, 99) < 5);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
